// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of an asynchronous serialiser for the console port.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frame) after the data bits.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wEn,
    input  logic [7:0]                    data,
    input  logic                          ovfClr,
    output logic                          txd,
    output logic                          full,
    output logic                          empty,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    // state  | meaning
    // IDLE   | line high, pops the next byte when the FIFO is non-empty
    // START  | start bit (low)
    // DATA   | eight data bits, LSB first
    // PARITY | even-parity bit (only with UART_TX_PARITY_EN)
    // STOP   | stop bit (high)

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rdPtr;
    logic [AW-1:0] wrPtr;
    logic [AW:0]   levelNext;
    logic          pop;
    logic          push;
    logic          drop;

    logic [2:0]    state;
    logic [CW-1:0] baudCnt;
    logic [2:0]    bitIdx;
    logic [7:0]    shiftReg;
    logic          baudTc;
`ifdef UART_TX_PARITY_EN
    logic          parityBit;
`endif

    assign pop    = (state == IDLE) && (level != '0);
    assign push   = wEn && ((level != FULL_LEVEL) || pop);
    assign drop   = wEn && !push;
    assign baudTc = (baudCnt == BAUD_LAST);
    assign busy   = (state != IDLE);

    always_comb begin
        levelNext = level;
        if (push && !pop) begin
            levelNext = level + 1'b1;
        end else if (pop && !push) begin
            levelNext = level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            level <= levelNext;
            full  <= (levelNext == FULL_LEVEL);
            empty <= (levelNext == '0);
            // a drop in the same cycle as a clear keeps the flag set
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovfClr) begin
                overflow <= 1'b0;
            end
        end
    end

    // txd is re-registered from the current state, so the line trails the FSM by one clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baudCnt   <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            txd       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parityBit <= 1'b0;
`endif
        end else begin
            if (state != IDLE) begin
                baudCnt <= baudTc ? '0 : baudCnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shiftReg  <= mem[rdPtr];
                        baudCnt   <= '0;
                        bitIdx    <= '0;
                        state     <= START;
`ifdef UART_TX_PARITY_EN
                        parityBit <= ^mem[rdPtr];
`endif
                    end
                end
                START: begin
                    txd <= 1'b0;
                    if (baudTc) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    txd <= shiftReg[0];
                    if (baudTc) begin
                        shiftReg <= shiftReg >> 1;
                        bitIdx   <= bitIdx + 1'b1;
                        if (bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    txd <= parityBit;
                    if (baudTc) begin
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    txd <= 1'b1;
                    if (baudTc) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue/arithmetic reference model checked every cycle, plus a
// line decoder and literal expectations for the directed scenarios.
module tb_uart_tx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wEn = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ovfClr = 1'b0;
    logic       txd, full, empty, busy, overflow;
    logic [3:0] level;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wEn(wEn), .data(data), .ovfClr(ovfClr),
        .txd(txd), .full(full), .empty(empty), .busy(busy),
        .overflow(overflow), .level(level)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mq[$];
    logic [7:0] acceptQ[$];
    int         mRemain = 0;
    logic [7:0] mCur = 8'h00;
    bit         mOvf = 1'b0;
    bit         mTxd = 1'b1;

    task automatic modelStep();
        bit pop, push;
        int k, b;
        mTxd = 1'b1;
        if (mRemain > 0) begin
            k = FL - mRemain;
            b = k / CPB;
            if (b == 0) mTxd = 1'b0;
            else if (b <= 8) mTxd = mCur[b-1];
`ifdef UART_TX_PARITY_EN
            else if (b == 9) mTxd = ^mCur;
`endif
            else mTxd = 1'b1;
        end
        pop = (mRemain == 0) && (mq.size() > 0);
        if (mRemain > 0) mRemain--;
        push = wEn && ((mq.size() < DEPTH) || pop);
        if (pop) begin
            mCur = mq.pop_front();
            mRemain = FL;
        end
        if (push) begin
            mq.push_back(data);
            acceptQ.push_back(data);
        end
        if (wEn && !push) mOvf = 1'b1;
        else if (ovfClr) mOvf = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                mRemain = 0;
                mOvf = 1'b0;
                mTxd = 1'b1;
            end else begin
                modelStep();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("txd", txd, mTxd);
            chk("level", level, mq.size());
            chk("full", full, mq.size() == DEPTH);
            chk("empty", empty, mq.size() == 0);
            chk("busy", busy, mRemain > 0);
            chk("overflow", overflow, mOvf);
        end
    end

    // ---------------- line decoder ----------------
    logic [7:0] rxQ[$];
    bit         rxPar[$];
    time        rxT[$];
    bit         rstSeen = 1'b0;

    initial forever @(posedge rst) rstSeen = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin : frame
                logic [7:0] b;
                bit s0, sp, p;
                time tf;
                tf = $time;
                rstSeen = 1'b0;
                p = 1'b0;
                repeat (CPB/2) @(negedge clk);
                s0 = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = txd;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                p = txd;
`endif
                repeat (CPB) @(negedge clk);
                sp = txd;
                if (!rstSeen) begin
                    chk("rx_start", s0, 1'b0);
                    chk("rx_stop", sp, 1'b1);
`ifdef UART_TX_PARITY_EN
                    chk("rx_parity", p, ^b);
`endif
                    rxQ.push_back(b);
                    rxPar.push_back(p);
                    rxT.push_back(tf);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic waitIdle(input int maxCyc);
        int n;
        n = 0;
        while ((mRemain > 0 || mq.size() > 0) && n < maxCyc) begin
            @(negedge clk);
            n++;
        end
        if (mRemain > 0 || mq.size() > 0) timeoutFail("wait_idle");
        repeat (5) @(negedge clk);
    endtask

    task automatic waitRx(input int cnt, input int maxCyc);
        int n;
        n = 0;
        while (rxQ.size() < cnt && n < maxCyc) begin
            @(negedge clk);
            n++;
        end
        if (rxQ.size() < cnt) timeoutFail("wait_rx");
    endtask

    task automatic chkRx(input string name, input int idx, input logic [7:0] exp);
        if (idx < rxQ.size()) chk(name, rxQ[idx], exp);
        else timeoutFail(name);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, bcnt, burst;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // idle after reset
        repeat (100) @(negedge clk);
        chk("idle_txd", txd, 1'b1);
        chk("idle_empty", empty, 1'b1);
        chk("idle_level", level, 0);
        chk("idle_busy", busy, 1'b0);

        // single byte 0xA5: latency and busy duration
        rxQ.delete(); rxT.delete(); rxPar.delete();
        wEn = 1'b1; data = 8'hA5;
        lat = 0; bcnt = 0;
        for (int i = 1; i <= FL + 40; i++) begin
            @(negedge clk);
            if (i == 1) wEn = 1'b0;
            if (busy === 1'b1) bcnt++;
            if (txd === 1'b0 && lat == 0) lat = i;
        end
        chk("a5_latency", lat, 3);
        chk("a5_busy_cycles", bcnt, FL);
        waitRx(1, 100);
        chkRx("a5_byte", 0, 8'hA5);
        waitIdle(2 * FL);

        // three consecutive bytes
        rxQ.delete(); rxT.delete(); rxPar.delete();
        wEn = 1'b1; data = 8'h48;
        @(negedge clk); data = 8'h69;
        @(negedge clk); data = 8'h0A;
        @(negedge clk); wEn = 1'b0;
        chk("three_level_peak", level, 2);
        waitRx(3, 3 * (FL + 1) + 100);
        chkRx("three_b0", 0, 8'h48);
        chkRx("three_b1", 1, 8'h69);
        chkRx("three_b2", 2, 8'h0A);
        if (rxT.size() >= 3) begin
            chk("gap_01", 32'((rxT[1] - rxT[0]) / 10), FL + 1);
            chk("gap_12", 32'((rxT[2] - rxT[1]) / 10), FL + 1);
        end else timeoutFail("gap");
        waitIdle(2 * FL);
        chk("three_empty", empty, 1'b1);

        // ten bytes into an 8-deep FIFO
        rxQ.delete(); rxT.delete(); rxPar.delete();
        for (int i = 0; i < 10; i++) begin
            wEn = 1'b1; data = 8'h10 + 8'(i);
            @(negedge clk);
        end
        wEn = 1'b0;
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_full", full, 1'b1);
        chk("ovf_level", level, 8);
        ovfClr = 1'b1;
        @(negedge clk);
        ovfClr = 1'b0;
        chk("ovf_cleared", overflow, 1'b0);
        waitRx(9, 9 * (FL + 1) + 100);
        for (int i = 0; i < 9; i++) chkRx("ovf_byte", i, 8'h10 + 8'(i));
        waitIdle(2 * FL);
        chk("ovf_rx_count", rxQ.size(), 9);

        // reset during data bit 3 of 0xC3, with a second byte queued
        rxQ.delete(); rxT.delete(); rxPar.delete();
        wEn = 1'b1; data = 8'hC3;
        @(negedge clk); data = 8'h3C;
        @(negedge clk); wEn = 1'b0;
        for (int i = 0; i < 20 && txd !== 1'b0; i++) @(negedge clk);
        repeat (4 * CPB + 8) @(negedge clk);
        chk("pre_rst_txd", txd, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_txd", txd, 1'b1);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_empty", empty, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (120) @(negedge clk);
        chk("post_rst_txd", txd, 1'b1);
        rxQ.delete(); rxT.delete(); rxPar.delete();
        wEn = 1'b1; data = 8'h55;
        @(negedge clk); wEn = 1'b0;
        waitRx(1, FL + 50);
        chkRx("post_rst_byte", 0, 8'h55);
        waitIdle(2 * FL);

`ifdef UART_TX_PARITY_EN
        rxQ.delete(); rxT.delete(); rxPar.delete();
        wEn = 1'b1; data = 8'h07;
        bcnt = 0;
        for (int i = 1; i <= FL + 40; i++) begin
            @(negedge clk);
            if (i == 1) wEn = 1'b0;
            if (busy === 1'b1) bcnt++;
        end
        chk("par_frame_len", bcnt, 176);
        wEn = 1'b1; data = 8'h03;
        @(negedge clk); wEn = 1'b0;
        waitRx(2, 2 * FL + 100);
        if (rxPar.size() >= 2) begin
            chk("par_07", rxPar[0], 1'b1);
            chk("par_03", rxPar[1], 1'b0);
        end else timeoutFail("par");
        waitIdle(2 * FL);
`endif

        // randomized traffic with occasional bursts and overflow clears
        rxQ.delete(); rxT.delete(); rxPar.delete(); acceptQ.delete();
        burst = 0;
        for (int c = 0; c < 4000; c++) begin
            if (burst > 0) begin
                wEn = 1'b1;
                burst--;
            end else begin
                wEn = ($urandom_range(0, 99) < 2);
                if ($urandom_range(0, 499) == 0) burst = $urandom_range(8, 12);
            end
            data = 8'($urandom_range(0, 255));
            ovfClr = ($urandom_range(0, 149) == 0);
            @(negedge clk);
        end
        wEn = 1'b0; ovfClr = 1'b0;
        waitIdle(12 * (FL + 1));
        repeat (20) @(negedge clk);
        chk("rand_rx_count", rxQ.size(), acceptQ.size());
        for (int i = 0; i < rxQ.size() && i < acceptQ.size(); i++)
            chk("rand_rx_byte", rxQ[i], acceptQ[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
